// File: rtl/mem_fu_arbiter_pkg.sv
// Shared types and widths for the memory functional-unit arbiter.
// The optional store-priority feature is selected with MEM_ARB_STORE_FIRST_EN.
package mem_arb_pkg;

    localparam int XLEN      = 32;
    localparam int BHW_W     = 3;
    localparam int N_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_fu_arbiter_rr_pick.sv
// Combinational round-robin picker: first set mask bit searching from last+1
// (modulo N) wins; the result is one-hot with a valid flag.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  win_oh_o,
    output logic          valid_o
);

    logic [IW-1:0] idx;

    always_comb begin
        win_oh_o = '0;
        valid_o  = 1'b0;
        idx      = '0;
        // k = N wraps back to last itself, so it is searched last.
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(last_i) + k) % N);
            if (!valid_o && mask_i[idx]) begin
                win_oh_o[idx] = 1'b1;
                valid_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_fu_arbiter.sv
// Round-robin owner of the single multi-cycle memory FU: issues one request,
// waits for fu_finish, returns a one-hot done. Optional: MEM_ARB_STORE_FIRST_EN.
module mem_fu_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic [N-1:0]        req_w,
    input  logic [BHW_W*N-1:0]  req_bhw,
    input  logic [XLEN*N-1:0]   req_rs1,
    input  logic [XLEN*N-1:0]   req_rs2,
    input  logic [XLEN*N-1:0]   req_imm,
    output logic [N-1:0]        gnt,
    output logic                fu_en,
    output logic                fu_mem_w,
    output logic [BHW_W-1:0]    fu_bhw,
    output logic [XLEN-1:0]     fu_rs1,
    output logic [XLEN-1:0]     fu_rs2,
    output logic [XLEN-1:0]     fu_imm,
    input  logic                fu_finish,
    input  logic [XLEN-1:0]     fu_mem_data,
    output logic [N-1:0]        done,
    output logic [XLEN-1:0]     done_data,
    output logic                busy,
    output logic [1:0]          state_o
);

    // Handshake: a requester holds req and its operands until its gnt bit pulses;
    // req is sampled only in IDLE, so a request withdrawn before gnt is never served.

    arb_state_t        state_q;
    logic [IW-1:0]     last_q;
    logic [IW-1:0]     win_q;
    logic [N-1:0]      win_oh_q;
    logic [N-1:0]      gnt_q;
    logic              fu_en_q;
    logic              fu_mem_w_q;
    logic [BHW_W-1:0]  fu_bhw_q;
    logic [XLEN-1:0]   fu_rs1_q;
    logic [XLEN-1:0]   fu_rs2_q;
    logic [XLEN-1:0]   fu_imm_q;
    logic [N-1:0]      done_q;
    logic [XLEN-1:0]   done_data_q;
    logic              busy_q;

    logic [N-1:0]      pick_oh;
    logic              pick_valid;
    logic [IW-1:0]     win_idx;

`ifdef MEM_ARB_STORE_FIRST_EN
    logic [N-1:0] st_oh;
    logic         st_valid;
    logic [N-1:0] all_oh;
    logic         all_valid;

    rr_pick #(.N(N), .IW(IW)) u_pick_st (
        .mask_i   (req & req_w),
        .last_i   (last_q),
        .win_oh_o (st_oh),
        .valid_o  (st_valid)
    );

    rr_pick #(.N(N), .IW(IW)) u_pick_all (
        .mask_i   (req),
        .last_i   (last_q),
        .win_oh_o (all_oh),
        .valid_o  (all_valid)
    );

    // Any pending store pre-empts every load.
    assign pick_oh    = st_valid ? st_oh : all_oh;
    assign pick_valid = all_valid;
`else
    rr_pick #(.N(N), .IW(IW)) u_pick_all (
        .mask_i   (req),
        .last_i   (last_q),
        .win_oh_o (pick_oh),
        .valid_o  (pick_valid)
    );
`endif

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_oh[i]) begin
                win_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= IW'(N - 1);
            win_q       <= '0;
            win_oh_q    <= '0;
            gnt_q       <= '0;
            fu_en_q     <= 1'b0;
            fu_mem_w_q  <= 1'b0;
            fu_bhw_q    <= '0;
            fu_rs1_q    <= '0;
            fu_rs2_q    <= '0;
            fu_imm_q    <= '0;
            done_q      <= '0;
            done_data_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        win_q      <= win_idx;
                        win_oh_q   <= pick_oh;
                        fu_mem_w_q <= req_w[win_idx];
                        fu_bhw_q   <= req_bhw[win_idx*BHW_W +: BHW_W];
                        fu_rs1_q   <= req_rs1[win_idx*XLEN +: XLEN];
                        fu_rs2_q   <= req_rs2[win_idx*XLEN +: XLEN];
                        fu_imm_q   <= req_imm[win_idx*XLEN +: XLEN];
                        // Outputs are registered, so the ISSUE-cycle pulses are set here.
                        fu_en_q    <= 1'b1;
                        gnt_q      <= pick_oh;
                        busy_q     <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    fu_en_q <= 1'b0;
                    gnt_q   <= '0;
                    last_q  <= win_q;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (fu_finish) begin
                        done_q      <= win_oh_q;
                        done_data_q <= fu_mem_w_q ? '0 : fu_mem_data;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    done_q      <= '0;
                    done_data_q <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign fu_en     = fu_en_q;
    assign fu_mem_w  = fu_mem_w_q;
    assign fu_bhw    = fu_bhw_q;
    assign fu_rs1    = fu_rs1_q;
    assign fu_rs2    = fu_rs2_q;
    assign fu_imm    = fu_imm_q;
    assign done      = done_q;
    assign done_data = done_data_q;
    assign busy      = busy_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mem_fu_arbiter.sv
// Directed bench for mem_fu_arbiter with a hand-driven two-cycle FU.
// Expectations follow the default build unless MEM_ARB_STORE_FIRST_EN is defined.
module tb_mem_fu_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_w = '0;
    logic [3*N-1:0]  req_bhw = '0;
    logic [32*N-1:0] req_rs1 = '0;
    logic [32*N-1:0] req_rs2 = '0;
    logic [32*N-1:0] req_imm = '0;
    logic [N-1:0]    gnt;
    logic            fu_en;
    logic            fu_mem_w;
    logic [2:0]      fu_bhw;
    logic [31:0]     fu_rs1;
    logic [31:0]     fu_rs2;
    logic [31:0]     fu_imm;
    logic            fu_finish = 1'b0;
    logic [31:0]     fu_mem_data = '0;
    logic [N-1:0]    done;
    logic [31:0]     done_data;
    logic            busy;
    logic [1:0]      state_o;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    mem_fu_arbiter #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_w       (req_w),
        .req_bhw     (req_bhw),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_imm     (req_imm),
        .gnt         (gnt),
        .fu_en       (fu_en),
        .fu_mem_w    (fu_mem_w),
        .fu_bhw      (fu_bhw),
        .fu_rs1      (fu_rs1),
        .fu_rs2      (fu_rs2),
        .fu_imm      (fu_imm),
        .fu_finish   (fu_finish),
        .fu_mem_data (fu_mem_data),
        .done        (done),
        .done_data   (done_data),
        .busy        (busy),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int idx, input logic w, input logic [2:0] bhw,
                          input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
        req_w[idx]             = w;
        req_bhw[idx*3 +: 3]    = bhw;
        req_rs1[idx*32 +: 32]  = rs1;
        req_rs2[idx*32 +: 32]  = rs2;
        req_imm[idx*32 +: 32]  = imm;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_state"}, 64'(state_o), 64'(S_IDLE));
        check({tag, "_gnt"}, 64'(gnt), 64'h0);
        check({tag, "_fu_en"}, 64'(fu_en), 64'h0);
        check({tag, "_busy"}, 64'(busy), 64'h0);
        check({tag, "_done"}, 64'(done), 64'h0);
        check({tag, "_done_data"}, 64'(done_data), 64'h0);
        check({tag, "_fu_mem_w"}, 64'(fu_mem_w), 64'h0);
        check({tag, "_fu_bhw"}, 64'(fu_bhw), 64'h0);
        check({tag, "_fu_rs1"}, 64'(fu_rs1), 64'h0);
        check({tag, "_fu_rs2"}, 64'(fu_rs2), 64'h0);
        check({tag, "_fu_imm"}, 64'(fu_imm), 64'h0);
    endtask

    // Entered in the grant cycle (cycle 1); returns in cycle 5 (back in IDLE).
    task automatic run_from_grant(input string tag, input logic [N-1:0] exp_oh,
                                  input logic [31:0] fu_data, input logic [31:0] exp_data);
        check({tag, "_gnt"}, 64'(gnt), 64'(exp_oh));
        check({tag, "_fu_en"}, 64'(fu_en), 64'h1);
        check({tag, "_busy_issue"}, 64'(busy), 64'h1);
        check({tag, "_state_issue"}, 64'(state_o), 64'(S_ISSUE));
        tick();
        check({tag, "_fu_en_wait"}, 64'(fu_en), 64'h0);
        check({tag, "_gnt_wait"}, 64'(gnt), 64'h0);
        check({tag, "_state_wait"}, 64'(state_o), 64'(S_WAIT));
        tick();
        fu_finish   = 1'b1;
        fu_mem_data = fu_data;
        check({tag, "_fu_en_wait2"}, 64'(fu_en), 64'h0);
        check({tag, "_done_early"}, 64'(done), 64'h0);
        tick();
        fu_finish   = 1'b0;
        fu_mem_data = 32'h0;
        check({tag, "_done"}, 64'(done), 64'(exp_oh));
        check({tag, "_done_data"}, 64'(done_data), 64'(exp_data));
        check({tag, "_busy_resp"}, 64'(busy), 64'h1);
        check({tag, "_fu_en_resp"}, 64'(fu_en), 64'h0);
        tick();
        check({tag, "_done_clear"}, 64'(done), 64'h0);
        check({tag, "_busy_clear"}, 64'(busy), 64'h0);
        check({tag, "_state_idle"}, 64'(state_o), 64'(S_IDLE));
    endtask

    initial begin
        logic [N-1:0] exp_first;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_idle_outputs("reset");

        // Single load from requester 0
        set_op(0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h4);
        req = 4'b0001;
        tick();
        req = 4'b0000;
        check("load_addr", 64'(fu_rs1 + fu_imm), 64'h104);
        check("load_mem_w", 64'(fu_mem_w), 64'h0);
        check("load_bhw", 64'(fu_bhw), 64'h2);
        run_from_grant("load", 4'b0001, 32'hDEADBEEF, 32'hDEADBEEF);

        // Fairness from a fresh reset: order 0,1,2,3,0, one grant every 5 cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            set_op(i, 1'b0, 3'b000, 32'h1000 + 32'(i), 32'h0, 32'h0);
        end
        req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            run_from_grant($sformatf("rr%0d", i), 4'(1 << (i % N)),
                           32'hA000_0000 + 32'(i), 32'hA000_0000 + 32'(i));
            if (i == 4) begin
                req = 4'b0000;
            end
            tick();
        end
        check("rr_drained", 64'(state_o), 64'(S_IDLE));

        // Store from requester 2 returns zero data even with FU data present
        set_op(2, 1'b1, 3'b001, 32'h200, 32'h55, 32'h8);
        req = 4'b0100;
        tick();
        req = 4'b0000;
        check("store_mem_w", 64'(fu_mem_w), 64'h1);
        check("store_rs2", 64'(fu_rs2), 64'h55);
        check("store_bhw", 64'(fu_bhw), 64'h1);
        check("store_rs1", 64'(fu_rs1), 64'h200);
        run_from_grant("store", 4'b0100, 32'h1234_5678, 32'h0);

        // Store priority after reset (last = 3), then reset while in WAIT
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_op(0, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0);
        set_op(1, 1'b1, 3'b010, 32'h310, 32'h77, 32'h0);
`ifdef MEM_ARB_STORE_FIRST_EN
        exp_first = 4'b0010;
`else
        exp_first = 4'b0001;
`endif
        req = 4'b0011;
        tick();
        req = 4'b0000;
        check("prio_gnt", 64'(gnt), 64'(exp_first));
        check("prio_fu_en", 64'(fu_en), 64'h1);
        tick();
        check("prio_wait", 64'(state_o), 64'(S_WAIT));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("rst_wait");
        fu_finish   = 1'b1;
        fu_mem_data = 32'hCAFE_F00D;
        tick();
        fu_finish   = 1'b0;
        fu_mem_data = 32'h0;
        check("stray_finish_done", 64'(done), 64'h0);
        check("stray_finish_state", 64'(state_o), 64'(S_IDLE));
        set_op(3, 1'b0, 3'b100, 32'h400, 32'h0, 32'h10);
        req = 4'b1000;
        tick();
        req = 4'b0000;
        check("post_rst_rs1", 64'(fu_rs1), 64'h400);
        run_from_grant("post_rst", 4'b1000, 32'h0BAD_CAFE, 32'h0BAD_CAFE);

        // Request from requester 2 that appears only during WAIT is never served
        set_op(0, 1'b0, 3'b010, 32'h500, 32'h0, 32'h0);
        req = 4'b0001;
        tick();
        req = 4'b0000;
        check("drop_gnt", 64'(gnt), 64'h1);
        tick();
        req = 4'b0100;
        tick();
        req         = 4'b0000;
        fu_finish   = 1'b1;
        fu_mem_data = 32'h0000_5A5A;
        tick();
        fu_finish   = 1'b0;
        fu_mem_data = 32'h0;
        check("drop_done_owner", 64'(done), 64'h1);
        check("drop_done_data", 64'(done_data), 64'h5A5A);
        for (int c = 0; c < 8; c++) begin
            tick();
            check($sformatf("drop_no_gnt%0d", c), 64'(gnt), 64'h0);
            check($sformatf("drop_no_done%0d", c), 64'(done), 64'h0);
            check($sformatf("drop_no_fu_en%0d", c), 64'(fu_en), 64'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
